crc_stream_engine: RTL and testbench

- Parametrised, clocked successor to the team's fixed 112-bit combinational CRC-16 block.
- Computes a CRC over a multi-beat frame streamed in DATA_W bits per cycle, with valid/ready/last handshake.
- Polynomial, init value, final XOR and width are configurable.
- Supports two modes:
  - Generate: outputs the CRC.
  - Check: verifies a frame that carries its CRC appended, with a zero-residue test.
- Sits between the UART byte deframer and the AES frame handler.

---
 rtl/crc_stream_engine.sv | 109 ++++++++++
 tb/tb_crc_stream_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: MSB-first LFSR over DATA_W-bit beats.
// Generates a CRC or checks a frame carrying its CRC (zero residue).
module crc_stream_engine #(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h8005,
    parameter logic [CRC_W-1:0] INIT    = 16'h0000,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
    parameter int               DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              mode_chk,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    output logic              crc_ok,
    input  logic              out_ready
);

    if (CRC_W < 4 || CRC_W > 32 || DATA_W < 1 || DATA_W > 128) begin : g_bad_cfg
        $error("crc_stream_engine: unsupported CRC_W or DATA_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           state;
    logic [CRC_W-1:0] lfsr;
    logic [CRC_W-1:0] lfsr_nxt;
    logic             mode_q;
    logic             mode_eff;
    logic             take;
    logic             fb;

    assign take     = in_valid && in_ready;
    assign mode_eff = (state == IDLE) ? mode_chk : mode_q;

    // lfsr already holds INIT whenever the engine is idle
    always_comb begin
        lfsr_nxt = lfsr;
        fb       = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb       = lfsr_nxt[CRC_W-1] ^ in_data[i];
            lfsr_nxt = {lfsr_nxt[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= INIT;
            mode_q    <= 1'b0;
            in_ready  <= 1'b1;
            crc_valid <= 1'b0;
            crc_ok    <= 1'b0;
            crc_out   <= '0;
        end else if (clear) begin
            state     <= IDLE;
            lfsr      <= INIT;
            in_ready  <= 1'b1;
            crc_valid <= 1'b0;
            crc_ok    <= 1'b0;
            crc_out   <= '0;
        end else begin
            unique case (state)
                IDLE, RUN: begin
                    if (take) begin
                        lfsr <= lfsr_nxt;
                        if (state == IDLE) begin
                            mode_q <= mode_chk;
                        end
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            crc_valid <= 1'b1;
                            crc_out   <= mode_eff ? lfsr_nxt : lfsr_nxt ^ XOR_OUT;
                            crc_ok    <= mode_eff && (lfsr_nxt == '0);
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        lfsr      <= INIT;
                        in_ready  <= 1'b1;
                        crc_valid <= 1'b0;
                        crc_ok    <= 1'b0;
                        crc_out   <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lfsr     <= INIT;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: byte-wide and bit-serial instances.
// Expected values are CRC-16/UMTS results worked out by hand.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clear;
    logic        mode_chk;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] crc_out;
    logic        crc_valid;
    logic        crc_ok;
    logic        out_ready;

    logic        s_clear;
    logic        s_mode;
    logic [0:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [15:0] s_crc_out;
    logic        s_crc_valid;
    logic        s_crc_ok;
    logic        s_out_ready;

    crc_stream_engine dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .mode_chk (mode_chk),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .crc_out  (crc_out),
        .crc_valid(crc_valid),
        .crc_ok   (crc_ok),
        .out_ready(out_ready)
    );

    crc_stream_engine #(.DATA_W(1)) dut_ser (
        .clk      (clk),
        .rst      (rst),
        .clear    (s_clear),
        .mode_chk (s_mode),
        .in_data  (s_data),
        .in_valid (s_valid),
        .in_last  (s_last),
        .in_ready (s_ready),
        .crc_out  (s_crc_out),
        .crc_valid(s_crc_valid),
        .crc_ok   (s_crc_ok),
        .out_ready(s_out_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] frame [16];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic load_msg();
        for (int i = 0; i < 9; i++) frame[i] = 8'h31 + 8'(i);
    endtask

    // Offer one beat; waits (bounded) for in_ready, returns at posedge+1.
    task automatic beat(input logic [7:0] d, input logic last);
        int w = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w == 20) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode_chk is only honoured on the first beat; flip it afterwards.
    task automatic send_frame(input int n, input logic md, input int gap);
        for (int i = 0; i < n; i++) begin
            mode_chk = (i == 0) ? md : ~md;
            beat(frame[i], i == n - 1);
            if (i != n - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        mode_chk = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] exp_crc,
                                 input logic exp_ok);
        check({tag, "_valid"}, 32'(crc_valid), 32'd1);
        check({tag, "_crc"}, 32'(crc_out), 32'(exp_crc));
        check({tag, "_ok"}, 32'(crc_ok), 32'(exp_ok));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_drop"}, 32'(crc_valid), 32'd0);
            check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int k;
        int cyc;
        logic took;
        logic [7:0] ch;

        rst = 1'b1; clear = 1'b0; mode_chk = 1'b0; in_data = '0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        s_clear = 1'b0; s_mode = 1'b0; s_data = '0; s_valid = 1'b0;
        s_last = 1'b0; s_out_ready = 1'b1;
        #12;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(crc_valid), 32'd0);
        check("rst_crc", 32'(crc_out), 32'd0);
        check("rst_ok", 32'(crc_ok), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        load_msg();
        send_frame(9, 1'b0, 0);
        expect_result("gen", 16'hFEE8, 1'b0);
        send_frame(9, 1'b0, 0);
        expect_result("b2b", 16'hFEE8, 1'b0);

        mode_chk = 1'b0;
        beat(8'h31, 1'b1);
        expect_result("single", 16'h80A5, 1'b0);

        frame[9]  = 8'hFE;
        frame[10] = 8'hE8;
        send_frame(11, 1'b1, 0);
        expect_result("chk_good", 16'h0000, 1'b1);
        frame[10] = 8'hE9;
        send_frame(11, 1'b1, 0);
        expect_result("chk_bad", 16'h8005, 1'b0);

        out_ready = 1'b0;
        send_frame(9, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            in_data  = 8'hAA;
            in_valid = 1'b1;
            in_last  = 1'b0;
            check("stall_valid", 32'(crc_valid), 32'd1);
            check("stall_crc", 32'(crc_out), 32'h0000FEE8);
            check("stall_rdy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_drop", 32'(crc_valid), 32'd0);
        send_frame(9, 1'b0, 0);
        expect_result("after_stall", 16'hFEE8, 1'b0);

        send_frame(9, 1'b0, 2);
        expect_result("gaps", 16'hFEE8, 1'b0);

        for (int i = 0; i < 4; i++) beat(frame[i], 1'b0);
        clear    = 1'b1;
        in_data  = 8'h55;
        in_valid = 1'b1;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("clr_valid", 32'(crc_valid), 32'd0);
        send_frame(9, 1'b0, 0);
        expect_result("after_clr", 16'hFEE8, 1'b0);

        out_ready = 1'b0;
        send_frame(9, 1'b0, 0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_hold_valid", 32'(crc_valid), 32'd0);
        check("clr_hold_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        for (int i = 0; i < 4; i++) beat(frame[i], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mid_rdy", 32'(in_ready), 32'd1);
        check("arst_mid_valid", 32'(crc_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(9, 1'b0, 0);
        expect_result("after_arst", 16'hFEE8, 1'b0);

        out_ready = 1'b0;
        send_frame(9, 1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_hold_valid", 32'(crc_valid), 32'd0);
        check("arst_hold_crc", 32'(crc_out), 32'd0);
        check("arst_hold_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        k   = 0;
        cyc = 0;
        while (k < 72 && cyc < 200) begin
            ch      = frame[k / 8];
            s_data  = ch[7 - (k % 8)];
            s_valid = 1'b1;
            s_last  = (k == 71);
            s_mode  = (k == 0) ? 1'b0 : 1'b1;
            took    = s_ready;
            @(posedge clk);
            #1;
            if (took) k++;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("ser_beats", 32'(k), 32'd72);
        check("ser_valid", 32'(s_crc_valid), 32'd1);
        check("ser_crc", 32'(s_crc_out), 32'h0000FEE8);
        check("ser_ok", 32'(s_crc_ok), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
